// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: scan/sequence controller in front of a SAR ADC core.
// Drives the analog mux select, waits for the mux to settle, issues a
// one-cycle start to the converter and tags the returned result with its
// channel. Round-robin background scanning plus one-shot priority requests.
// Optional build macro: ADC_SCAN_AVG_EN converts each selection four times
// and reports the truncated average.

module adc_scan_sequencer #(
  parameter int ADC_WIDTH    = 8,
  parameter int CH_NUM       = 4,
  parameter int CH_W         = 2,
  parameter int SETTLE_CYC   = 4,
  parameter int CONV_TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 scan_en,
  input  logic [CH_NUM-1:0]    ch_mask,
  input  logic                 single_req,
  input  logic [CH_W-1:0]      single_ch,
  output logic                 adc_start,
  input  logic                 adc_eoc,
  input  logic                 adc_den,
  input  logic [ADC_WIDTH-1:0] adc_dout,
  output logic [CH_W-1:0]      mux_sel,
  output logic                 res_valid,
  output logic [CH_W-1:0]      res_ch,
  output logic [ADC_WIDTH-1:0] res_data,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int CNT_MAX = (CONV_TIMEOUT > SETTLE_CYC) ? CONV_TIMEOUT : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(CONV_TIMEOUT - 1);
  localparam logic [CH_W-1:0]  LAST_CH_RST = CH_W'(CH_NUM - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CH_W-1:0]        mux_sel_q, mux_sel_d;
  logic [CH_W-1:0]        last_ch_q, last_ch_d;
  logic                   is_scan_q, is_scan_d;
  logic                   adc_start_q, adc_start_d;
  logic                   res_valid_q, res_valid_d;
  logic [CH_W-1:0]        res_ch_q, res_ch_d;
  logic [ADC_WIDTH-1:0]   res_data_q, res_data_d;
  logic                   busy_q, busy_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [CH_W:0]          scan_pick;

`ifdef ADC_SCAN_AVG_EN
  logic [ADC_WIDTH+1:0]   acc_q, acc_d;
  logic [1:0]             pass_q, pass_d;
  logic [ADC_WIDTH+1:0]   acc_sum;

  assign acc_sum = acc_q + {2'b00, adc_dout};
`endif

  // Round-robin search: first enabled channel strictly after last, wrapping.
  // Returns {found, channel}.
  function automatic logic [CH_W:0] pick_next(input logic [CH_W-1:0]   last,
                                               input logic [CH_NUM-1:0] mask);
    logic              found;
    logic [CH_W-1:0]   ch;
    logic [CH_NUM-1:0] sh;
    int                idx;
    found = 1'b0;
    ch    = '0;
    for (int i = 1; i <= CH_NUM; i++) begin
      idx = int'(last) + i;
      if (idx >= CH_NUM) idx = idx - CH_NUM;
      sh = mask >> idx;
      if (!found && sh[0]) begin
        found = 1'b1;
        ch    = CH_W'(idx);
      end
    end
    return {found, ch};
  endfunction

  // Next-state and next-output computation for the sequencing FSM.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mux_sel_d     = mux_sel_q;
    last_ch_d     = last_ch_q;
    is_scan_d     = is_scan_q;
    adc_start_d   = 1'b0;
    res_valid_d   = 1'b0;
    res_ch_d      = res_ch_q;
    res_data_d    = res_data_q;
    timeout_err_d = 1'b0;
`ifdef ADC_SCAN_AVG_EN
    acc_d         = acc_q;
    pass_d        = pass_q;
`endif
    scan_pick     = pick_next(last_ch_q, ch_mask);

    case (state_q)
      IDLE: begin
`ifdef ADC_SCAN_AVG_EN
        acc_d  = '0;
        pass_d = '0;
`endif
        if (single_req) begin
          if (int'(single_ch) < CH_NUM) begin
            mux_sel_d = single_ch;
            is_scan_d = 1'b0;
            cnt_d     = '0;
            state_d   = SETTLE;
          end
        end else if (scan_en && scan_pick[CH_W]) begin
          mux_sel_d = scan_pick[CH_W-1:0];
          is_scan_d = 1'b1;
          cnt_d     = '0;
          state_d   = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          adc_start_d = 1'b1;
          state_d     = START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (adc_eoc && adc_den) begin
`ifdef ADC_SCAN_AVG_EN
          if (pass_q == 2'd3) begin
            res_valid_d = 1'b1;
            res_ch_d    = mux_sel_q;
            res_data_d  = acc_sum[ADC_WIDTH+1:2];
            if (is_scan_q) last_ch_d = mux_sel_q;
            state_d     = DONE;
          end else begin
            acc_d       = acc_sum;
            pass_d      = pass_q + 1'b1;
            adc_start_d = 1'b1;
            state_d     = START;
          end
`else
          res_valid_d = 1'b1;
          res_ch_d    = mux_sel_q;
          res_data_d  = adc_dout;
          if (is_scan_q) last_ch_d = mux_sel_q;
          state_d     = DONE;
`endif
        end else if (cnt_q == WAIT_LAST) begin
          timeout_err_d = 1'b1;
          if (is_scan_q) last_ch_d = mux_sel_q;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset clears everything at once so a
  // pending start is dropped immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mux_sel_q     <= '0;
      last_ch_q     <= LAST_CH_RST;
      is_scan_q     <= 1'b0;
      adc_start_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_ch_q      <= '0;
      res_data_q    <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
      acc_q         <= '0;
      pass_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mux_sel_q     <= mux_sel_d;
      last_ch_q     <= last_ch_d;
      is_scan_q     <= is_scan_d;
      adc_start_q   <= adc_start_d;
      res_valid_q   <= res_valid_d;
      res_ch_q      <= res_ch_d;
      res_data_q    <= res_data_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
`ifdef ADC_SCAN_AVG_EN
      acc_q         <= acc_d;
      pass_q        <= pass_d;
`endif
    end
  end

  assign adc_start   = adc_start_q;
  assign mux_sel     = mux_sel_q;
  assign res_valid   = res_valid_q;
  assign res_ch      = res_ch_q;
  assign res_data    = res_data_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Testbench for adc_scan_sequencer: directed scenarios against a small
// behavioural SAR model, with hand-computed expected results.
// Build with ADC_SCAN_AVG_EN defined to exercise the averaging variant.

module tb_adc_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       scan_en;
  logic [3:0] ch_mask;
  logic       single_req;
  logic [1:0] single_ch;
  logic       adc_start;
  logic       adc_eoc;
  logic       adc_den;
  logic [7:0] adc_dout;
  logic [1:0] mux_sel;
  logic       res_valid;
  logic [1:0] res_ch;
  logic [7:0] res_data;
  logic       busy;
  logic       timeout_err;

  int tests_run;
  int tests_failed;
  int cyc;

  logic [1:0] got_ch[$];
  logic [7:0] got_data[$];
  int         got_cyc[$];

  // SAR model controls: mode 0 fixed value, 1 channel*16, 2 never answers,
  // 3 returns 10,11,12,13 in turn
  int         model_mode;
  int         model_lat;
  logic [7:0] model_val;
  int         start_count;
  int         model_cnt;
  bit         model_pend;
  bit         start_prev;
  logic [7:0] model_data;

  adc_scan_sequencer #(
    .ADC_WIDTH(8), .CH_NUM(4), .CH_W(2), .SETTLE_CYC(4), .CONV_TIMEOUT(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .ch_mask(ch_mask),
    .single_req(single_req), .single_ch(single_ch), .adc_start(adc_start),
    .adc_eoc(adc_eoc), .adc_den(adc_den), .adc_dout(adc_dout),
    .mux_sel(mux_sel), .res_valid(res_valid), .res_ch(res_ch),
    .res_data(res_data), .busy(busy), .timeout_err(timeout_err)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural SAR core: answers model_lat cycles after a start rising edge
  initial begin
    adc_eoc    = 1'b0;
    adc_den    = 1'b0;
    adc_dout   = 8'h00;
    model_pend = 1'b0;
    start_prev = 1'b0;
    model_cnt  = 0;
    model_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      adc_eoc = 1'b0;
      adc_den = 1'b0;
      if (model_pend) begin
        model_cnt = model_cnt - 1;
        if (model_cnt == 0) begin
          adc_eoc    = 1'b1;
          adc_den    = 1'b1;
          adc_dout   = model_data;
          model_pend = 1'b0;
        end
      end
      if (adc_start && !start_prev) begin
        if (model_mode != 2) begin
          model_pend = 1'b1;
          model_cnt  = model_lat;
          case (model_mode)
            0:       model_data = model_val;
            1:       model_data = {2'b00, mux_sel, 4'h0};
            default: model_data = 8'(10 + (start_count % 4));
          endcase
        end
        start_count = start_count + 1;
      end
      start_prev = adc_start;
    end
  end

  // Result monitor: logs every res_valid strobe with its cycle number
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (res_valid) begin
        got_ch.push_back(res_ch);
        got_data.push_back(res_data);
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic scan, input logic [3:0] mask,
                               input logic sreq, input logic [1:0] sch);
    scan_en    = scan;
    ch_mask    = mask;
    single_req = sreq;
    single_ch  = sch;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clearLog();
    got_ch.delete();
    got_data.delete();
    got_cyc.delete();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 4'b0000, 1'b0, 2'd0);
    repeat (3) tick();
    checkOutput("reset_outs",
                32'({adc_start, busy, mux_sel, res_valid, res_ch, res_data, timeout_err}),
                32'h0);
    model_pend  = 1'b0;
    start_count = 0;
    clearLog();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic waitResults(input int want, input int limit, input string tag);
    int n;
    n = 0;
    while (got_ch.size() < want && n < limit) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(got_ch.size()), 32'(want));
  endtask

  task automatic waitStart(input int limit, input string tag, output int n);
    n = 0;
    while (!adc_start && n < limit) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(adc_start), 32'h1);
  endtask

  task automatic drain();
    int n;
    applyStimulus(1'b0, 4'b0000, 1'b0, 2'd0);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    checkOutput("drain_idle", 32'(busy), 32'h0);
  endtask

  initial begin
    int n;
    int exp_ch_scan[5];
    int exp_dat_scan[5];
    int exp_ch_prio[4];
    int exp_dat_prio[4];
    exp_ch_scan  = '{0, 1, 3, 0, 1};
    exp_dat_scan = '{'h00, 'h10, 'h30, 'h00, 'h10};
    exp_ch_prio  = '{0, 1, 2, 3};
    exp_dat_prio = '{'h00, 'h10, 'h20, 'h30};
    tests_run    = 0;
    tests_failed = 0;
    model_mode   = 0;
    model_lat    = 8;
    model_val    = 8'h00;
    start_count  = 0;
    rst_n        = 1'b0;
    applyStimulus(1'b0, 4'b0000, 1'b0, 2'd0);

`ifdef ADC_SCAN_AVG_EN
    // Averaging: four conversions of channel 1, values 10..13 -> 11
    doReset();
    model_mode = 3;
    applyStimulus(1'b0, 4'b0000, 1'b1, 2'd1);
    tick();
    applyStimulus(1'b0, 4'b0000, 1'b0, 2'd0);
    waitResults(1, 300, "avg_result_count");
    if (got_ch.size() >= 1) begin
      checkOutput("avg_ch", 32'(got_ch[0]), 32'h1);
      checkOutput("avg_data", 32'(got_data[0]), 32'd11);
    end
    checkOutput("avg_starts", 32'(start_count), 32'd4);
    repeat (5) tick();
    checkOutput("avg_single_valid", 32'(got_ch.size()), 32'd1);
    checkOutput("avg_busy_low", 32'(busy), 32'h0);
`else
    // Single request on channel 2, model returns 0xA5 after 8 cycles
    doReset();
    model_mode = 0;
    model_val  = 8'hA5;
    applyStimulus(1'b0, 4'b0000, 1'b1, 2'd2);
    tick();
    applyStimulus(1'b0, 4'b0000, 1'b0, 2'd0);
    checkOutput("single_busy", 32'(busy), 32'h1);
    checkOutput("single_mux", 32'(mux_sel), 32'h2);
    repeat (3) tick();
    checkOutput("single_start_early", 32'(adc_start), 32'h0);
    tick();
    checkOutput("single_start_T5", 32'(adc_start), 32'h1);
    n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput("single_latency", 32'(n), 32'd9);
    checkOutput("single_res_ch", 32'(res_ch), 32'h2);
    checkOutput("single_res_data", 32'(res_data), 32'hA5);
    tick();
    checkOutput("single_valid_pulse", 32'(res_valid), 32'h0);
    checkOutput("single_busy_fall", 32'(busy), 32'h0);
    checkOutput("single_data_hold", 32'(res_data), 32'hA5);

    // Scan with an empty mask never leaves IDLE; then mask 1011 round-robin
    doReset();
    model_mode = 1;
    applyStimulus(1'b1, 4'b0000, 1'b0, 2'd0);
    repeat (5) tick();
    checkOutput("scan_empty_mask_idle", 32'(busy), 32'h0);
    applyStimulus(1'b1, 4'b1011, 1'b0, 2'd0);
    waitResults(5, 300, "scan_result_count");
    applyStimulus(1'b0, 4'b1011, 1'b0, 2'd0);
    if (got_ch.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        checkOutput($sformatf("scan_ch%0d", i), 32'(got_ch[i]), 32'(exp_ch_scan[i]));
        checkOutput($sformatf("scan_data%0d", i), 32'(got_data[i]), 32'(exp_dat_scan[i]));
      end
      checkOutput("scan_period", 32'(got_cyc[1] - got_cyc[0]), 32'd15);
    end
    drain();

    // Single request for ch 2 raised while ch 1 is converting
    doReset();
    model_mode = 1;
    applyStimulus(1'b1, 4'b1011, 1'b0, 2'd0);
    waitResults(1, 100, "prio_first_result");
    n = 0;
    while (!(busy && mux_sel == 2'd1) && n < 50) begin
      tick();
      n++;
    end
    checkOutput("prio_ch1_active", 32'(mux_sel), 32'h1);
    applyStimulus(1'b1, 4'b1011, 1'b1, 2'd2);
    n = 0;
    while (!(busy && mux_sel == 2'd2) && n < 100) begin
      tick();
      n++;
    end
    checkOutput("prio_ch2_taken", 32'(mux_sel), 32'h2);
    applyStimulus(1'b1, 4'b1011, 1'b0, 2'd0);
    waitResults(4, 200, "prio_result_count");
    applyStimulus(1'b0, 4'b1011, 1'b0, 2'd0);
    if (got_ch.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("prio_ch%0d", i), 32'(got_ch[i]), 32'(exp_ch_prio[i]));
        checkOutput($sformatf("prio_data%0d", i), 32'(got_data[i]), 32'(exp_dat_prio[i]));
      end
    end
    drain();

    // Model never answers ch 0: timeout, then ch 1 proceeds normally
    doReset();
    model_mode = 2;
    applyStimulus(1'b1, 4'b1011, 1'b0, 2'd0);
    waitStart(50, "to_start_seen", n);
    n = 0;
    while (!timeout_err && n < 60) begin
      tick();
      n++;
    end
    checkOutput("to_latency", 32'(n), 32'd33);
    checkOutput("to_busy_low", 32'(busy), 32'h0);
    checkOutput("to_no_valid", 32'(got_ch.size()), 32'h0);
    model_mode = 1;
    tick();
    checkOutput("to_pulse_width", 32'(timeout_err), 32'h0);
    waitResults(1, 100, "to_next_result");
    applyStimulus(1'b0, 4'b1011, 1'b0, 2'd0);
    if (got_ch.size() >= 1) begin
      checkOutput("to_next_ch", 32'(got_ch[0]), 32'h1);
      checkOutput("to_next_data", 32'(got_data[0]), 32'h10);
    end
    drain();

    // Reset asserted while ch 1 is in WAIT; late eoc must be ignored
    doReset();
    model_mode = 1;
    applyStimulus(1'b1, 4'b1011, 1'b0, 2'd0);
    waitResults(1, 100, "rst_first_result");
    waitStart(50, "rst_ch1_start", n);
    repeat (3) tick();
    applyStimulus(1'b0, 4'b1011, 1'b0, 2'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_outs",
                32'({adc_start, busy, mux_sel, res_valid, res_ch, res_data, timeout_err}),
                32'h0);
    clearLog();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (13) tick();
    checkOutput("rst_late_eoc_ignored", 32'(got_ch.size()), 32'h0);
    checkOutput("rst_idle", 32'(busy), 32'h0);
    applyStimulus(1'b1, 4'b1011, 1'b0, 2'd0);
    waitResults(1, 100, "rst_restart_result");
    applyStimulus(1'b0, 4'b1011, 1'b0, 2'd0);
    if (got_ch.size() >= 1) begin
      checkOutput("rst_restart_ch", 32'(got_ch[0]), 32'h0);
    end
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
